// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ producers.
// Grants one byte per frame, waits for the frame, then enforces a gap.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 1023,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Tx_en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [ID_W-1:0]           active_id,
    output logic                      busy,
    output logic                      done,
    output logic                      err_timeout
);

    localparam int CNT_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DONE,
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  req_s_q;
    logic                en_s_q;
    logic                txb_s_q;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                tx_start_q, tx_start_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [ID_W-1:0]     active_id_q, active_id_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                win_found;
    logic [ID_W-1:0]     win_id;
    logic [CNT_W-1:0]    cnt_inc;

    // Round-robin search starting just above the last winner, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!win_found && req_s_q[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // Saturating increment so a counter can never wrap back to zero.
    always_comb begin
        cnt_inc = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next-state and next-output logic for the grant/ack/done/gap sequence.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        grant_d     = '0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        active_id_d = active_id_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en_s_q && win_found) begin
                    grant_d     = NUM_REQ'(1) << win_id;
                    tx_start_d  = 1'b1;
                    tx_data_d   = req_data[int'(win_id)*DATA_W +: DATA_W];
                    active_id_d = win_id;
                    ptr_d       = win_id;
                    state_d     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (txb_s_q) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt_q >= CNT_W'(ACK_TIMEOUT)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_DONE: begin
                if (!txb_s_q) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q >= CNT_W'(GAP_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, input samplers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            cnt_q       <= '0;
            req_s_q     <= '0;
            en_s_q      <= 1'b0;
            txb_s_q     <= 1'b0;
            grant_q     <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            active_id_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            req_s_q     <= req;
            en_s_q      <= Tx_en;
            txb_s_q     <= tx_busy;
            grant_q     <= grant_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            active_id_q <= active_id_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign grant       = grant_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign active_id   = active_id_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model.
// Latencies below follow a 160-cycle frame, GAP_CYCLES=16, ACK_TIMEOUT=1023.
module tb_uart_tx_arbiter;

    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int GAPC  = 16;
    localparam int ACKT  = 1023;
    localparam int FRAME = 160;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          Tx_en = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR*DW-1:0] req_data = {8'hA5, 8'h79, 8'h33, 8'h75};
    logic [NR-1:0] grant;
    logic [DW-1:0] tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic [1:0]    active_id;
    logic          busy;
    logic          done;
    logic          err_timeout;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic tx_auto = 1'b1;
    logic [15:0] bcnt;

    uart_tx_arbiter #(
        .NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(GAPC), .ACK_TIMEOUT(ACKT)
    ) dut (
        .clk(clk), .rst(rst), .Tx_en(Tx_en), .req(req), .req_data(req_data),
        .grant(grant), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .active_id(active_id), .busy(busy),
        .done(done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy for FRAME cycles starting the edge after tx_start.
    always @(posedge clk or posedge rst) begin
        if (rst) bcnt <= '0;
        else if (tx_start && tx_auto) bcnt <= 16'(FRAME);
        else if (bcnt != 0) bcnt <= bcnt - 16'd1;
    end
    assign tx_busy = (bcnt != 0);

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ev(input int which);
        case (which)
            0: return grant != '0;
            1: return done === 1'b1;
            2: return err_timeout === 1'b1;
            default: return busy === 1'b0;
        endcase
    endfunction

    // Advance at least one negedge, then until the event or the limit.
    task automatic wait_ev(input int which, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ev(which) && n < limit);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int dsnap;
        int gcount;
        logic [7:0] bytes [4];
        bytes[0] = 8'h75; bytes[1] = 8'h33; bytes[2] = 8'h79; bytes[3] = 8'hA5;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_active_id", 32'(active_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err_timeout), 0);
        rst = 1'b0;

        // Single requester
        @(negedge clk);
        Tx_en = 1'b1;
        req = 4'b0001;
        wait_ev(0, 10, n);
        chk("single_lat", n, 2);
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_start", 32'(tx_start), 1);
        chk("single_data", 32'(tx_data), 32'h75);
        chk("single_id", 32'(active_id), 0);
        chk("single_busy", 32'(busy), 1);
        @(negedge clk);
        chk("single_grant_pulse", 32'(grant), 0);
        chk("single_start_pulse", 32'(tx_start), 0);
        wait_ev(1, 400, n);
        chk("single_done_lat", n + 1, 163);
        @(negedge clk);
        chk("single_done_pulse", 32'(done), 0);
        wait_ev(0, 400, n);
        chk("single_regrant_gap", n + 1, 18);
        chk("single_regrant", 32'(grant), 32'h1);
        req = '0;
        wait_ev(3, 400, n);
        chk("single_idle", 32'(busy), 0);

        // Simultaneous requests from reset pointer: 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ev(0, 400, n);
            chk("rr_spacing", n, (i == 0) ? 2 : 181);
            chk("rr_grant", 32'(grant), 32'(1 << (i % 4)));
            chk("rr_data", 32'(tx_data), 32'(bytes[i % 4]));
            chk("rr_id", 32'(active_id), i % 4);
        end
        req = '0;
        wait_ev(3, 400, n);
        chk("rr_idle", 32'(busy), 0);

        // Fairness after wrap: ptr=2, req=1001 -> 3 then 0
        do_reset();
        req = 4'b0100;
        wait_ev(0, 10, n);
        chk("wrap_g2", 32'(grant), 32'h4);
        chk("wrap_d2", 32'(tx_data), 32'h79);
        req = 4'b1001;
        wait_ev(0, 400, n);
        chk("wrap_g3", 32'(grant), 32'h8);
        chk("wrap_d3", 32'(tx_data), 32'hA5);
        wait_ev(0, 400, n);
        chk("wrap_g0", 32'(grant), 32'h1);
        req = '0;
        wait_ev(3, 400, n);
        chk("wrap_idle", 32'(busy), 0);

        // Timeout: transmitter never acknowledges
        tx_auto = 1'b0;
        req = 4'b0010;
        wait_ev(0, 10, n);
        chk("to_grant", 32'(grant), 32'h2);
        chk("to_data", 32'(tx_data), 32'h33);
        req = '0;
        dsnap = done_cnt;
        wait_ev(2, 1100, n);
        chk("to_lat", n, ACKT + 1);
        chk("to_err", 32'(err_timeout), 1);
        wait_ev(3, 100, n);
        chk("to_idle_lat", n, GAPC + 1);
        chk("to_no_done", done_cnt, dsnap);
        tx_auto = 1'b1;

        // Tx_en gating
        Tx_en = 1'b0;
        req = 4'b0001;
        gcount = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (grant != '0) gcount++;
        end
        chk("en_no_grant", gcount, 0);
        Tx_en = 1'b1;
        wait_ev(0, 10, n);
        chk("en_lat", n, 2);
        chk("en_grant", 32'(grant), 32'h1);
        Tx_en = 1'b0;
        req = '0;
        wait_ev(1, 400, n);
        chk("en_done_lat", n, 163);
        wait_ev(3, 400, n);
        chk("en_idle", 32'(busy), 0);

        // Reset mid-frame
        Tx_en = 1'b1;
        req = 4'b0001;
        wait_ev(0, 10, n);
        chk("mid_grant", 32'(grant), 32'h1);
        req = '0;
        repeat (20) @(negedge clk);
        chk("mid_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_data", 32'(tx_data), 0);
        chk("mid_rst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0100;
        wait_ev(0, 10, n);
        chk("mid_after_lat", n, 2);
        chk("mid_after_grant", 32'(grant), 32'h4);
        chk("mid_after_id", 32'(active_id), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
